wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_if.sv | 31 +++
 rtl/wb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the MEM/WB pipe, the multicycle units and the register file write port.
// The arbiter uses the slave modport; the producers/consumer side uses master.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              pipe_we_i;
  logic [ADDR_W-1:0] pipe_waddr_i;
  logic [DATA_W-1:0] pipe_wdata_i;
  logic              mc_valid_i;
  logic [ADDR_W-1:0] mc_waddr_i;
  logic [DATA_W-1:0] mc_wdata_i;
  logic              mc_ready_o;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;

  modport slave (
    input  pipe_we_i, pipe_waddr_i, pipe_wdata_i,
    input  mc_valid_i, mc_waddr_i, mc_wdata_i,
    output mc_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport master (
    output pipe_we_i, pipe_waddr_i, pipe_wdata_i,
    output mc_valid_i, mc_waddr_i, mc_wdata_i,
    input  mc_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipe result has priority, multicycle results queue in a compacting FIFO.
// Optional statistics counters are built when WB_ARB_STATS_EN is defined.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  wb_arbiter_if.slave              bus,
  input  logic [ADDR_W-1:0]        chk_addr_a_i,
  input  logic [ADDR_W-1:0]        chk_addr_b_i,
  output logic                     hazard_o,
  output logic                     stall_req_o,
  output logic [$clog2(DEPTH):0]   pend_cnt_o,
  output logic [15:0]              stat_kill_cnt_o,
  output logic [$clog2(DEPTH):0]   stat_hwm_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [GW-1:0] AGE_LIM = GW'(STARVE_MAX - 1);

  logic [DEPTH-1:0][ADDR_W-1:0] r_addr, w_n_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data, w_n_data;
  logic [DEPTH-1:0]             r_vld, w_n_vld, w_kill;
  logic [CW-1:0]                r_cnt, w_k;
  logic [GW-1:0]                r_age, w_n_age;
  logic                         r_we, r_stall, w_n_stall;
  logic [ADDR_W-1:0]            r_waddr;
  logic [DATA_W-1:0]            r_wdata;
  logic w_empty, w_pipe_iss, w_pop, w_mc_nz, w_bypass, w_ready, w_xfer;
  logic w_push, w_push_kill, w_a_nz, w_b_nz, w_hz_fifo, w_hz_mc;

  assign w_empty     = (r_cnt == '0);
  assign w_pipe_iss  = bus.pipe_we_i && (bus.pipe_waddr_i != '0);
  assign w_pop       = !w_pipe_iss && !w_empty;
  assign w_mc_nz     = bus.mc_valid_i && (bus.mc_waddr_i != '0);
  assign w_bypass    = !w_pipe_iss && w_empty && w_mc_nz;
  assign w_ready     = (r_cnt != FULL_C);
  assign w_xfer      = bus.mc_valid_i && w_ready;
  // A result arriving alongside a pipe write to the same register is older than it: drop it.
  assign w_push_kill = w_xfer && w_mc_nz && w_pipe_iss && (bus.mc_waddr_i == bus.pipe_waddr_i);
  assign w_push      = w_xfer && w_mc_nz && !w_bypass && !w_push_kill;

  // Next queue contents: drop popped/killed entries, compact toward slot 0, append push.
  always_comb begin
    w_n_addr = '0;
    w_n_data = '0;
    w_n_vld  = '0;
    w_kill   = '0;
    w_k      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = w_pipe_iss && r_vld[i] && (r_addr[i] == bus.pipe_waddr_i);
      if (r_vld[i] && !w_kill[i] && !(w_pop && i == 0)) begin
        w_n_addr[w_k[AW-1:0]] = r_addr[i];
        w_n_data[w_k[AW-1:0]] = r_data[i];
        w_n_vld[w_k[AW-1:0]]  = 1'b1;
        w_k = w_k + 1'b1;
      end
    end
    if (w_push) begin
      w_n_addr[w_k[AW-1:0]] = bus.mc_waddr_i;
      w_n_data[w_k[AW-1:0]] = bus.mc_wdata_i;
      w_n_vld[w_k[AW-1:0]]  = 1'b1;
      w_k = w_k + 1'b1;
    end
  end

  assign w_a_nz = (chk_addr_a_i != '0);
  assign w_b_nz = (chk_addr_b_i != '0);

  always_comb begin
    w_hz_fifo = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && ((w_a_nz && r_addr[i] == chk_addr_a_i) ||
                       (w_b_nz && r_addr[i] == chk_addr_b_i)))
        w_hz_fifo = 1'b1;
    end
  end

  assign w_hz_mc  = bus.mc_valid_i && !w_bypass &&
                    ((w_a_nz && bus.mc_waddr_i == chk_addr_a_i) ||
                     (w_b_nz && bus.mc_waddr_i == chk_addr_b_i));
  assign hazard_o = w_hz_fifo || w_hz_mc;

  // Head age only grows while a live head is passed over and something remains queued.
  always_comb begin
    w_n_age   = '0;
    w_n_stall = 1'b0;
    if (!w_empty && !w_pop && (w_k != '0)) begin
      w_n_age   = (r_age == AGE_LIM) ? r_age : r_age + 1'b1;
      w_n_stall = (r_age >= AGE_LIM);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_vld   <= '0;
      r_cnt   <= '0;
      r_age   <= '0;
      r_stall <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_addr  <= w_n_addr;
      r_data  <= w_n_data;
      r_vld   <= w_n_vld;
      r_cnt   <= w_k;
      r_age   <= w_n_age;
      r_stall <= w_n_stall;
      r_we    <= w_pipe_iss || w_pop || w_bypass;
      if (w_pipe_iss) begin
        r_waddr <= bus.pipe_waddr_i;
        r_wdata <= bus.pipe_wdata_i;
      end else if (w_pop) begin
        r_waddr <= r_addr[0];
        r_wdata <= r_data[0];
      end else if (w_bypass) begin
        r_waddr <= bus.mc_waddr_i;
        r_wdata <= bus.mc_wdata_i;
      end else begin
        r_waddr <= '0;
        r_wdata <= '0;
      end
    end
  end

  assign bus.mc_ready_o = w_ready;
  assign bus.rf_we_o    = r_we;
  assign bus.rf_waddr_o = r_waddr;
  assign bus.rf_wdata_o = r_wdata;
  assign stall_req_o    = r_stall;
  assign pend_cnt_o     = r_cnt;

`ifdef WB_ARB_STATS_EN
  logic [15:0]   r_kill;
  logic [CW-1:0] r_hwm;
  logic [CW:0]   w_nkill;
  logic [16:0]   w_kill_sum;

  always_comb begin
    w_nkill = {{CW{1'b0}}, w_push_kill};
    for (int i = 0; i < DEPTH; i++)
      w_nkill = w_nkill + {{CW{1'b0}}, w_kill[i]};
  end

  assign w_kill_sum = {1'b0, r_kill} + 17'(w_nkill);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kill <= '0;
      r_hwm  <= '0;
    end else begin
      r_kill <= w_kill_sum[16] ? 16'hFFFF : w_kill_sum[15:0];
      if (w_k > r_hwm) r_hwm <= w_k;
    end
  end

  assign stat_kill_cnt_o = r_kill;
  assign stat_hwm_o      = r_hwm;
`else
  assign stat_kill_cnt_o = '0;
  assign stat_hwm_o      = '0;
`endif

  // The pipeline must honour a stall; if it doesn't, the pipe still wins but flag it.
  a_stall_honoured: assert property (@(posedge clk) disable iff (!rst) r_stall |-> !bus.pipe_we_i);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table for single-cycle behaviour plus
// hand sequences for starvation and asynchronous reset.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  chk_a, chk_b;
  logic        hazard, stall;
  logic [2:0]  pend, hwm;
  logic [15:0] kills;
  int          n_chk = 0;
  int          n_err = 0;

  wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .chk_addr_a_i    (chk_a),
    .chk_addr_b_i    (chk_b),
    .hazard_o        (hazard),
    .stall_req_o     (stall),
    .pend_cnt_o      (pend),
    .stat_kill_cnt_o (kills),
    .stat_hwm_o      (hwm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  ca, cb;
    logic        er, eh, ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [2:0]  ep;
  } vec_t;

  vec_t vq[$];

  function automatic void add(int pwe, int pa, int pd, int mv, int ma, int md, int ca, int cb,
                              int er, int eh, int ew, int ea, int ed, int ep);
    vec_t v;
    v.pwe = pwe[0]; v.pa = 5'(pa); v.pd = 32'(pd);
    v.mv  = mv[0];  v.ma = 5'(ma); v.md = 32'(md);
    v.ca  = 5'(ca); v.cb = 5'(cb);
    v.er  = er[0];  v.eh = eh[0];  v.ew = ew[0];
    v.ea  = 5'(ea); v.ed = 32'(ed); v.ep = 3'(ep);
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bus.pipe_we_i = pwe; bus.pipe_waddr_i = pa; bus.pipe_wdata_i = pd;
    bus.mc_valid_i = mv; bus.mc_waddr_i = ma; bus.mc_wdata_i = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   pwe pa  pd           mv ma  md        ca  cb  rdy haz  we ea  ed           pend
    add(1,  3, 'h12345678,   0, 0,  0,        3,  0,  1,  0,   1, 3,  'h12345678,  0);
    add(1,  0, 'hFFFF,       0, 0,  0,        0,  0,  1,  0,   0, 0,  0,           0);
    add(0,  0, 0,            1, 7,  'hDEAD,   7,  0,  1,  0,   1, 7,  'hDEAD,      0);
    add(0,  0, 0,            1, 0,  1,        0,  0,  1,  0,   0, 0,  0,           0);
    add(1,  1, 'h11,         1, 4,  'h44,     4,  0,  1,  1,   1, 1,  'h11,        1);
    add(1,  1, 'h12,         1, 5,  'h55,     4,  5,  1,  1,   1, 1,  'h12,        2);
    add(1,  1, 'h13,         1, 6,  'h66,     2,  0,  1,  0,   1, 1,  'h13,        3);
    add(1,  1, 'h14,         1, 7,  'h77,     6,  0,  1,  1,   1, 1,  'h14,        4);
    add(1,  1, 'h15,         1, 8,  'h88,     8,  0,  0,  1,   1, 1,  'h15,        4);
    add(0,  0, 0,            0, 0,  0,        4,  0,  0,  1,   1, 4,  'h44,        3);
    add(0,  0, 0,            0, 0,  0,        4,  0,  1,  0,   1, 5,  'h55,        2);
    add(0,  0, 0,            0, 0,  0,        7,  0,  1,  1,   1, 6,  'h66,        1);
    add(0,  0, 0,            0, 0,  0,        7,  0,  1,  1,   1, 7,  'h77,        0);
    add(0,  0, 0,            0, 0,  0,        7,  0,  1,  0,   0, 0,  0,           0);
    add(1,  1, 'h21,         1, 9,  'hAAAA,   9,  0,  1,  1,   1, 1,  'h21,        1);
    add(1,  9, 'hBBBB,       0, 0,  0,        0,  9,  1,  1,   1, 9,  'hBBBB,      0);
    add(0,  0, 0,            0, 0,  0,        9,  0,  1,  0,   0, 0,  0,           0);
    add(1, 10, 'hC0,         1, 10, 'hC1,     10, 0,  1,  1,   1, 10, 'hC0,        0);
    add(0,  0, 0,            0, 0,  0,        10, 0,  1,  0,   0, 0,  0,           0);
    add(1,  2, 1,            1, 11, 'hB1,     0,  0,  1,  0,   1, 2,  1,           1);
    add(1,  2, 2,            1, 12, 'hC2,     0,  0,  1,  0,   1, 2,  2,           2);
    add(1, 11, 3,            1, 13, 'hD3,     11, 0,  1,  1,   1, 11, 3,           2);
    add(0,  0, 0,            0, 0,  0,        11, 13, 1,  1,   1, 12, 'hC2,        1);
    add(0,  0, 0,            0, 0,  0,        12, 0,  1,  0,   1, 13, 'hD3,        0);
    add(0,  0, 0,            0, 0,  0,        0,  0,  1,  0,   0, 0,  0,           0);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk_a = '0; chk_b = '0;
    #3;
    chk("rst_we",    32'(bus.rf_we_o), 0);
    chk("rst_waddr", 32'(bus.rf_waddr_o), 0);
    chk("rst_wdata", bus.rf_wdata_o, 0);
    chk("rst_pend",  32'(pend), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ready", 32'(bus.mc_ready_o), 1);
    #9 rst = 1'b1;
    step();

    foreach (vq[i]) begin
      drive(vq[i].pwe, vq[i].pa, vq[i].pd, vq[i].mv, vq[i].ma, vq[i].md);
      chk_a = vq[i].ca; chk_b = vq[i].cb;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.mc_ready_o), 32'(vq[i].er));
      chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(vq[i].eh));
      step();
      chk($sformatf("v%0d_we", i), 32'(bus.rf_we_o), 32'(vq[i].ew));
      if (vq[i].ew) begin
        chk($sformatf("v%0d_waddr", i), 32'(bus.rf_waddr_o), 32'(vq[i].ea));
        chk($sformatf("v%0d_wdata", i), bus.rf_wdata_o, vq[i].ed);
      end
      chk($sformatf("v%0d_pend", i), 32'(pend), 32'(vq[i].ep));
      chk($sformatf("v%0d_stall", i), 32'(stall), 0);
    end
    chk_a = '0; chk_b = '0;

`ifdef WB_ARB_STATS_EN
    chk("stat_kill", 32'(kills), 3);
    chk("stat_hwm",  32'(hwm), 4);
`else
    chk("stat_kill", 32'(kills), 0);
    chk("stat_hwm",  32'(hwm), 0);
`endif

    // Starvation: queue one entry behind a continuously writing pipe.
    drive(1, 1, 'h31, 1, 20, 'h2020);
    step();
    chk("starve_pend", 32'(pend), 1);
    bus.mc_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus.pipe_wdata_i = 32'(k);
      step();
      chk($sformatf("starve_stall_e%0d", k), 32'(stall), (k == 8) ? 1 : 0);
    end
    bus.pipe_we_i = 1'b0;
    step();
    chk("starve_pop_we",    32'(bus.rf_we_o), 1);
    chk("starve_pop_waddr", 32'(bus.rf_waddr_o), 20);
    chk("starve_pop_wdata", bus.rf_wdata_o, 'h2020);
    chk("starve_release",   32'(stall), 0);
    chk("starve_pend_end",  32'(pend), 0);

    // Async reset with three queued entries.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 'h40, 1, 5'(21 + k), 32'('h500 + k));
      step();
    end
    chk("arst_pre_pend", 32'(pend), 3);
    chk("arst_pre_we",   32'(bus.rf_we_o), 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_we",    32'(bus.rf_we_o), 0);
    chk("arst_waddr", 32'(bus.rf_waddr_o), 0);
    chk("arst_wdata", bus.rf_wdata_o, 0);
    chk("arst_pend",  32'(pend), 0);
    drive(0, 0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("arst_post_we%0d", k), 32'(bus.rf_we_o), 0);
      chk($sformatf("arst_post_pend%0d", k), 32'(pend), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
